// File: rtl/stopwatch_bcd.sv
// SS.cc BCD stopwatch feeding the 4-digit seven-segment multiplexer (n4 leftmost, n1 rightmost).
// Optional lap freeze is compiled in with `define STOPWATCH_LAP_EN.
module stopwatch_bcd #(
    parameter int TICK_DIV = 500000,
    localparam int CNT_W   = $clog2(TICK_DIV)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start_stop,
    input  logic       btn_clear,
    input  logic       btn_lap,
    output logic [3:0] n1,
    output logic [3:0] n2,
    output logic [3:0] n3,
    output logic [3:0] n4,
    output logic       running,
    output logic       wrap,
    output logic       lap_active,
    output logic [1:0] state_dbg_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    localparam logic [CNT_W-1:0] PRESC_MAX = CNT_W'(TICK_DIV - 1);

    // Bit 0 is start/stop, bit 1 is clear: 2-FF synchronizer plus edge history.
    logic [1:0] btn_s1_q, btn_s2_q, btn_prev_q;
    logic [1:0] btn_edge;
    logic       ss_edge, clr_edge;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic [3:0]       d1_q, d2_q, d3_q, d4_q;
    logic [3:0]       d1_d, d2_d, d3_d, d4_d;
    logic             running_q, running_d;
    logic             wrap_q, wrap_d;
    logic             tick;
    logic             clear_all;
    logic [15:0]      live_d, live_q, disp;

    assign btn_edge = btn_s2_q & ~btn_prev_q;
    assign ss_edge  = btn_edge[0];
    assign clr_edge = btn_edge[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1_q   <= 2'b00;
            btn_s2_q   <= 2'b00;
            btn_prev_q <= 2'b00;
        end else begin
            btn_s1_q   <= {btn_clear, btn_start_stop};
            btn_s2_q   <= btn_s1_q;
            btn_prev_q <= btn_s2_q;
        end
    end

    // Clear only has effect from PAUSE, where it also beats a simultaneous start/stop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (ss_edge) state_d = ST_RUN;
            ST_RUN:   if (ss_edge) state_d = ST_PAUSE;
            ST_PAUSE: begin
                if (clr_edge)     state_d = ST_IDLE;
                else if (ss_edge) state_d = ST_RUN;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    assign clear_all = (state_q == ST_PAUSE) && clr_edge;
    assign tick      = (state_q == ST_RUN) && (presc_q == PRESC_MAX);

    always_comb begin
        presc_d = presc_q;
        if (clear_all)
            presc_d = '0;
        else if (state_q == ST_RUN)
            presc_d = tick ? '0 : presc_q + CNT_W'(1);
    end

    always_comb begin
        d1_d = d1_q;
        d2_d = d2_q;
        d3_d = d3_q;
        d4_d = d4_q;
        if (clear_all) begin
            d1_d = 4'd0;
            d2_d = 4'd0;
            d3_d = 4'd0;
            d4_d = 4'd0;
        end else if (tick) begin
            if (d1_q >= 4'd9) begin
                d1_d = 4'd0;
                if (d2_q >= 4'd9) begin
                    d2_d = 4'd0;
                    if (d3_q >= 4'd9) begin
                        d3_d = 4'd0;
                        d4_d = (d4_q >= 4'd5) ? 4'd0 : d4_q + 4'd1;
                    end else begin
                        d3_d = d3_q + 4'd1;
                    end
                end else begin
                    d2_d = d2_q + 4'd1;
                end
            end else begin
                d1_d = d1_q + 4'd1;
            end
        end
    end

    assign wrap_d    = tick && (d4_q == 4'd5) && (d3_q == 4'd9) && (d2_q == 4'd9) && (d1_q == 4'd9);
    assign running_d = (state_d == ST_RUN);
    assign live_d    = {d4_d, d3_d, d2_d, d1_d};
    assign live_q    = {d4_q, d3_q, d2_q, d1_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            d1_q      <= 4'd0;
            d2_q      <= 4'd0;
            d3_q      <= 4'd0;
            d4_q      <= 4'd0;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            d1_q      <= d1_d;
            d2_q      <= d2_d;
            d3_q      <= d3_d;
            d4_q      <= d4_d;
            running_q <= running_d;
            wrap_q    <= wrap_d;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic        lap_s1_q, lap_s2_q, lap_prev_q;
    logic        lap_edge;
    logic        lap_q, lap_d;
    logic [15:0] snap_q, snap_d;

    assign lap_edge = lap_s2_q & ~lap_prev_q;

    // The snapshot takes the value being registered this cycle so the display never skips.
    always_comb begin
        lap_d  = lap_q;
        snap_d = snap_q;
        if (clear_all) begin
            lap_d = 1'b0;
        end else if ((state_q == ST_RUN) && lap_edge) begin
            lap_d = ~lap_q;
            if (!lap_q) snap_d = live_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_s1_q   <= 1'b0;
            lap_s2_q   <= 1'b0;
            lap_prev_q <= 1'b0;
            lap_q      <= 1'b0;
            snap_q     <= 16'h0000;
        end else begin
            lap_s1_q   <= btn_lap;
            lap_s2_q   <= lap_s1_q;
            lap_prev_q <= lap_s2_q;
            lap_q      <= lap_d;
            snap_q     <= snap_d;
        end
    end

    assign disp       = lap_q ? snap_q : live_q;
    assign lap_active = lap_q;
`else
    logic unused_btn_lap;
    assign unused_btn_lap = btn_lap;
    assign disp           = live_q;
    assign lap_active     = 1'b0;
`endif

    assign n1          = disp[3:0];
    assign n2          = disp[7:4];
    assign n3          = disp[11:8];
    assign n4          = disp[15:12];
    assign running     = running_q;
    assign wrap        = wrap_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed bench for stopwatch_bcd at TICK_DIV=4: expected display values are queued as stimulus
// is issued and a negedge monitor pops one each time the display changes.
module tb_stopwatch_bcd;

    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_ss = 1'b0;
    logic       btn_clr = 1'b0;
    logic       btn_lap = 1'b0;
    logic [3:0] n1, n2, n3, n4;
    logic       running, wrap, lap_active;
    logic [1:0] state_dbg;
    logic [15:0] disp;

    int          total = 0;
    int          bad = 0;
    int          wrap_cnt = 0;
    logic        mon_en = 1'b0;
    logic [15:0] prev_disp = 16'h0000;
    logic [15:0] exp_q[$];

    stopwatch_bcd #(.TICK_DIV(TICK_DIV)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .btn_start_stop (btn_ss),
        .btn_clear      (btn_clr),
        .btn_lap        (btn_lap),
        .n1             (n1),
        .n2             (n2),
        .n3             (n3),
        .n4             (n4),
        .running        (running),
        .wrap           (wrap),
        .lap_active     (lap_active),
        .state_dbg_o    (state_dbg)
    );

    assign disp = {n4, n3, n2, n1};

    // Clock / reset block
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Total centiseconds -> SS.cc as four BCD nibbles.
    function automatic logic [15:0] to_bcd(input int cs);
        int s;
        int c;
        s = (cs / 100) % 60;
        c = cs % 100;
        return {4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Driver tasks: mask bit0 start/stop, bit1 clear, bit2 lap; one-cycle pulse from a negedge.
    task automatic press(input int mask);
        btn_ss  = mask[0];
        btn_clr = mask[1];
        btn_lap = mask[2];
        @(negedge clk);
        btn_ss  = 1'b0;
        btn_clr = 1'b0;
        btn_lap = 1'b0;
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_range(input int first, input int last);
        for (int i = first; i <= last; i++) exp_q.push_back(to_bcd(i));
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (mon_en) begin
            if (disp !== prev_disp) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL monitor_unexpected: got %h expected no change", disp);
                end else begin
                    check("monitor_seq", {16'h0, disp}, {16'h0, exp_q.pop_front()});
                end
                prev_disp = disp;
            end
            if (wrap === 1'b1) wrap_cnt++;
        end
    end

    initial begin
        wait_n(3);
        check("reset_disp", {16'h0, disp}, 32'h0);
        check("reset_running", {31'h0, running}, 32'h0);
        check("reset_wrap", {31'h0, wrap}, 32'h0);
        check("reset_lap_active", {31'h0, lap_active}, 32'h0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        wait_n(40);
        check("idle_disp", {16'h0, disp}, 32'h0);
        check("idle_running", {31'h0, running}, 32'h0);
        check("idle_state", {30'h0, state_dbg}, 32'h0);

        // Start: RUN on 3rd posedge, first tick 4 posedges later.
        push_range(1, 10);
        press(1);
        wait_n(1);
        check("start_running_early", {31'h0, running}, 32'h0);
        wait_n(1);
        check("start_running", {31'h0, running}, 32'h1);
        wait_n(3);
        check("first_tick_early", {16'h0, disp}, 32'h0);
        wait_n(1);
        check("first_tick", {16'h0, disp}, 32'h0001);
        wait_n(35);

        // Pause lands two cycles after the tick that showed 0010.
        press(1);
        check("count_40", {16'h0, disp}, 32'h0010);
        wait_n(1);
        check("pause_running_early", {31'h0, running}, 32'h1);
        wait_n(1);
        check("pause_running", {31'h0, running}, 32'h0);
        wait_n(20);
        check("pause_hold", {16'h0, disp}, 32'h0010);

        push_range(11, 11);
        press(1);
        wait_n(1);
        check("resume_running_early", {31'h0, running}, 32'h0);
        wait_n(1);
        check("resume_running", {31'h0, running}, 32'h1);
        wait_n(1);
        check("resume_no_early_tick", {16'h0, disp}, 32'h0010);
        wait_n(1);
        check("resume_fraction", {16'h0, disp}, 32'h0011);

        // Clear while running is ignored.
        push_range(12, 13);
        press(2);
        wait_n(7);
        check("clear_in_run_disp", {16'h0, disp}, 32'h0013);
        check("clear_in_run_running", {31'h0, running}, 32'h1);

        // Run to 01.23, pause, then start/stop and clear together.
        push_range(14, 123);
        wait_n(440);
        check("count_0123", {16'h0, disp}, 32'h0123);
        press(1);
        wait_n(2);
        check("pause2_running", {31'h0, running}, 32'h0);
        check("pause2_disp", {16'h0, disp}, 32'h0123);
        exp_q.push_back(16'h0000);
        press(3);
        wait_n(1);
        check("clear_prio_early", {16'h0, disp}, 32'h0123);
        wait_n(1);
        check("clear_prio_disp", {16'h0, disp}, 32'h0);
        check("clear_prio_running", {31'h0, running}, 32'h0);
        check("clear_prio_state", {30'h0, state_dbg}, 32'h0);

        // Full minute rollover.
        push_range(1, 6001);
        press(1);
        wait_n(2);
        check("roll_start_running", {31'h0, running}, 32'h1);
        wait_n(23999);
        check("roll_5999", {16'h0, disp}, 32'h5999);
        check("roll_wrap_before", {31'h0, wrap}, 32'h0);
        wait_n(1);
        check("roll_0000", {16'h0, disp}, 32'h0);
        check("roll_wrap_pulse", {31'h0, wrap}, 32'h1);
        check("roll_running", {31'h0, running}, 32'h1);
        wait_n(1);
        check("roll_wrap_after", {31'h0, wrap}, 32'h0);
        wait_n(3);
        check("roll_continue", {16'h0, disp}, 32'h0001);
        check("wrap_count", wrap_cnt, 32'd1);

        // Asynchronous reset mid-count.
        exp_q.push_back(16'h0000);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_disp", {16'h0, disp}, 32'h0);
        check("async_reset_running", {31'h0, running}, 32'h0);
        wait_n(1);
        rst_n = 1'b1;
        wait_n(1);

`ifdef STOPWATCH_LAP_EN
        push_range(1, 42);
        press(1);
        wait_n(170);
        check("lap_pre_0042", {16'h0, disp}, 32'h0042);
        press(4);
        wait_n(2);
        check("lap_active_on", {31'h0, lap_active}, 32'h1);
        check("lap_frozen_start", {16'h0, disp}, 32'h0042);
        wait_n(77);
        check("lap_frozen_80", {16'h0, disp}, 32'h0042);
        exp_q.push_back(16'h0062);
        press(4);
        wait_n(1);
        check("lap_release_early", {31'h0, lap_active}, 32'h1);
        wait_n(1);
        check("lap_active_off", {31'h0, lap_active}, 32'h0);
        check("lap_live_0062", {16'h0, disp}, 32'h0062);
`else
        push_range(1, 2);
        press(1);
        wait_n(2);
        press(4);
        wait_n(8);
        check("lap_ignored_active", {31'h0, lap_active}, 32'h0);
        check("lap_ignored_disp", {16'h0, disp}, 32'h0002);
`endif

        check("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
